// File: rtl/matmul_loader_if.sv
// Byte-stream input and packed-operand output bundle of the 3x3 matmul operand loader.
// Both sides use valid/ready: a beat moves on a rising edge where valid and ready are both high.
interface matmul_loader_if #(
    parameter int ELEM_W = 8
);
    logic [ELEM_W-1:0]   in_data;
    logic                in_valid;
    logic                in_ready;
    logic [9*ELEM_W-1:0] A_out;
    logic [9*ELEM_W-1:0] B_out;
    logic                mat_valid;
    logic                mat_ready;
    logic [4:0]          elem_cnt;
    logic                err_cksum;
    logic [1:0]          dbg_state;

    modport master (
        output in_data, in_valid, mat_ready,
        input  in_ready, A_out, B_out, mat_valid, elem_cnt, err_cksum, dbg_state
    );

    modport slave (
        input  in_data, in_valid, mat_ready,
        output in_ready, A_out, B_out, mat_valid, elem_cnt, err_cksum, dbg_state
    );
endinterface

// File: rtl/matmul_loader.sv
// Assembles a row-major byte stream into packed 3x3 operands A and B for the multiplier.
// Optional trailing checksum byte is enabled by defining MATMUL_LOADER_CKSUM_EN.
module matmul_loader #(
    parameter int ELEM_W = 8,
    parameter int DIM    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    matmul_loader_if.slave  bus
);
    localparam int N_ELEM = DIM * DIM;
    localparam int MAT_W  = N_ELEM * ELEM_W;

`ifdef MATMUL_LOADER_CKSUM_EN
    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD, CKSUM} state_t;
`else
    typedef enum logic [1:0] {LOAD_A, LOAD_B, HOLD} state_t;
`endif

    state_t             state, state_n;
    logic [3:0]         idx, idx_n;
    logic [MAT_W-1:0]   a_q, a_n;
    logic [MAT_W-1:0]   b_q, b_n;
    logic               mv_q, mv_n;
    logic               rdy_q, rdy_n;
    logic [4:0]         cnt_q, cnt_n;
    logic               xfer;
    logic               last_elem;
`ifdef MATMUL_LOADER_CKSUM_EN
    logic [ELEM_W-1:0]  sum_q, sum_n;
    logic               err_q, err_n;
`endif

    // Element k lands in slot k counted from the MSB end, so [0][0] is the top byte.
    function automatic logic [MAT_W-1:0] put_elem(
        input logic [MAT_W-1:0]  m,
        input logic [3:0]        k,
        input logic [ELEM_W-1:0] d
    );
        logic [MAT_W-1:0] r;
        r = m;
        for (int i = 0; i < N_ELEM; i++) begin
            if (k == 4'(i)) begin
                r[(N_ELEM-1-i)*ELEM_W +: ELEM_W] = d;
            end
        end
        return r;
    endfunction

    assign xfer      = bus.in_valid && rdy_q;
    assign last_elem = (idx == 4'(N_ELEM - 1));

    always_comb begin
        state_n = state;
        idx_n   = idx;
        a_n     = a_q;
        b_n     = b_q;
        mv_n    = mv_q;
        rdy_n   = rdy_q;
        cnt_n   = cnt_q;
`ifdef MATMUL_LOADER_CKSUM_EN
        sum_n   = sum_q;
        err_n   = 1'b0;
`endif
        if (clear) begin
            // Flush wins over any transfer or output handshake on the same edge.
            state_n = LOAD_A;
            idx_n   = '0;
            a_n     = '0;
            b_n     = '0;
            mv_n    = 1'b0;
            rdy_n   = 1'b1;
            cnt_n   = '0;
`ifdef MATMUL_LOADER_CKSUM_EN
            sum_n   = '0;
`endif
        end else begin
            case (state)
                LOAD_A: begin
                    rdy_n = 1'b1;
                    if (xfer) begin
                        a_n   = put_elem(a_q, idx, bus.in_data);
                        cnt_n = cnt_q + 5'd1;
`ifdef MATMUL_LOADER_CKSUM_EN
                        sum_n = sum_q + bus.in_data;
`endif
                        if (last_elem) begin
                            idx_n   = '0;
                            state_n = LOAD_B;
                        end else begin
                            idx_n = idx + 4'd1;
                        end
                    end
                end
                LOAD_B: begin
                    rdy_n = 1'b1;
                    if (xfer) begin
                        b_n   = put_elem(b_q, idx, bus.in_data);
                        cnt_n = cnt_q + 5'd1;
`ifdef MATMUL_LOADER_CKSUM_EN
                        sum_n = sum_q + bus.in_data;
`endif
                        if (last_elem) begin
                            idx_n = '0;
`ifdef MATMUL_LOADER_CKSUM_EN
                            state_n = CKSUM;
`else
                            state_n = HOLD;
                            rdy_n   = 1'b0;
                            mv_n    = 1'b1;
`endif
                        end else begin
                            idx_n = idx + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    mv_n  = 1'b1;
                    rdy_n = 1'b0;
                    if (mv_q && bus.mat_ready) begin
                        state_n = LOAD_A;
                        mv_n    = 1'b0;
                        rdy_n   = 1'b1;
                        cnt_n   = '0;
`ifdef MATMUL_LOADER_CKSUM_EN
                        sum_n   = '0;
`endif
                    end
                end
`ifdef MATMUL_LOADER_CKSUM_EN
                CKSUM: begin
                    rdy_n = 1'b1;
                    if (xfer) begin
                        if (bus.in_data == sum_q) begin
                            state_n = HOLD;
                            rdy_n   = 1'b0;
                            mv_n    = 1'b1;
                            cnt_n   = cnt_q + 5'd1;
                        end else begin
                            // Bad frame: drop it and restart clean.
                            state_n = LOAD_A;
                            err_n   = 1'b1;
                            a_n     = '0;
                            b_n     = '0;
                            cnt_n   = '0;
                            sum_n   = '0;
                        end
                    end
                end
`endif
                default: begin
                    state_n = LOAD_A;
                    idx_n   = '0;
                    mv_n    = 1'b0;
                    rdy_n   = 1'b1;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            mv_q  <= 1'b0;
            rdy_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            a_q   <= a_n;
            b_q   <= b_n;
            mv_q  <= mv_n;
            rdy_q <= rdy_n;
            cnt_q <= cnt_n;
        end
    end

`ifdef MATMUL_LOADER_CKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else begin
            sum_q <= sum_n;
            err_q <= err_n;
        end
    end
    assign bus.err_cksum = err_q;
`else
    assign bus.err_cksum = 1'b0;
`endif

    assign bus.in_ready  = rdy_q;
    assign bus.A_out     = a_q;
    assign bus.B_out     = b_q;
    assign bus.mat_valid = mv_q;
    assign bus.elem_cnt  = cnt_q;
    assign bus.dbg_state = state;
endmodule

// File: doc/matmul_loader.md
Name: matmul_loader

Overview:
Input staging block directly upstream of the 3x3 matrix multiplier. Accepts a byte stream of matrix elements over a valid/ready handshake and assembles operand A, then operand B, into the 72-bit packed format the multiplier consumes. Presents both operands together, held stable, under a valid/ready handshake. Frees the multiplier from needing 144 parallel input wires.

Parameters:
ELEM_W, 8, element width in bits; the packed operand width is 9*ELEM_W.
DIM, 3, matrix dimension; only 3 is supported, fixed by the multiplier packing.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous frame flush
in_data  input  ELEM_W  element byte, row-major, all of A then all of B
in_valid  input  1  in_data valid
in_ready  output  1  loader can accept in_data
A_out  output  9*ELEM_W  packed matrix A
B_out  output  9*ELEM_W  packed matrix B
mat_valid  output  1  A_out/B_out hold a complete frame
mat_ready  input  1  downstream consumes the frame
elem_cnt  output  5  elements accepted in the current frame, 0..18 (19 with checksum)
err_cksum  output  1  one-cycle checksum failure pulse

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values: in_ready=0, mat_valid=0, A_out=0, B_out=0, elem_cnt=0, err_cksum=0, state=LOAD_A.
- On the first rising edge after rst_n deasserts, in_ready goes to 1.
- All outputs are registered. There are no combinational paths from input to output.
- Transfer condition: in_valid && in_ready on a rising edge.
- States:
  - LOAD_A: the k-th transfer (k=0..8) writes element [k/3][k%3] of A. Packing places [0][0] at the MSBs, so A_out[(9-k)*ELEM_W-1 -: ELEM_W]. After the 9th transfer, go to LOAD_B.
  - LOAD_B: same indexing into B_out. After the 9th transfer, go to HOLD (or CKSUM when the feature is enabled).
  - HOLD: mat_valid=1 and in_ready=0. A_out/B_out are frozen. When mat_valid && mat_ready, go to LOAD_A on the next edge, with mat_valid=0, in_ready=1 and elem_cnt=0.
- in_ready deasserts on the same edge that captures the 18th byte. It is never high while mat_valid is high.
- Throughput: at most one frame per 19 cycles (18 transfers plus 1 HOLD cycle with mat_ready already high).
- A_out/B_out change only while mat_valid=0. Their contents during loading are partial but deterministic.
- elem_cnt increments on each transfer and holds in HOLD.
- mat_ready is ignored outside HOLD.
- A held in_valid with in_ready=0 does not transfer, and the byte is not lost upstream.
- clear, when high at an edge:
  - return to LOAD_A with elem_cnt=0, mat_valid=0, A_out=B_out=0, in_ready=1;
  - clear beats a simultaneous transfer (byte dropped) and a simultaneous mat_ready handshake (frame dropped).
- Reset mid-frame or in HOLD: the frame is discarded and all reset values apply immediately.
- No arithmetic on data; element values pass through bit-exact.

Optional Feature:
MATMUL_LOADER_CKSUM_EN
- Defined:
  - After the 18th element, state CKSUM accepts one more byte with in_ready=1.
  - Expected value = ELEM_W-bit modular sum of the 18 elements.
  - Match: go to HOLD and present the frame.
  - Mismatch: err_cksum pulses high for exactly one cycle, the frame is discarded, A_out/B_out are cleared, mat_valid stays 0, and the state returns to LOAD_A.
  - elem_cnt reaches 19.
- Undefined:
  - No CKSUM state; the 18th byte leads directly to HOLD.
  - err_cksum is tied to 0.

Test Plan:
1. Reset release, stream A=01..09 and B=01,00,00,00,01,00,00,00,01 with in_valid constant and mat_ready=1 -> A_out=72'h010203040506070809, B_out=72'h010000000100000001, mat_valid high for 1 cycle, next frame starts 19 cycles after the first.
2. Same frame, mat_ready=0 for 5 cycles in HOLD -> mat_valid and operands stable for 6 cycles, in_ready=0 throughout, in_ready=1 the cycle after the handshake.
3. 4 bytes accepted, then clear asserted together with in_valid -> elem_cnt=0, A_out=0, the byte is dropped, and a following full frame loads correctly.
4. rst_n pulsed low while in HOLD with mat_ready=0 -> mat_valid=0 and A_out=B_out=0 immediately, in_ready=1 one edge after release.
5. Random in_valid gaps (50% duty) across 3 back-to-back frames -> each frame is delivered bit-exact, in order, with no duplicated or dropped elements.
6. (MATMUL_LOADER_CKSUM_EN) Frame from test 1 plus checksum byte 8'h30 -> presented. Same frame with 8'h31 -> err_cksum 1-cycle pulse, mat_valid never set, next frame accepted normally.
